// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte sender: inhibit, request-to-send, 11-bit frame, ACK sample. Pad edge to data update 3 cycles.
// Backpressure: ready_out is high only in IDLE; valid_in is ignored during a transaction.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int RTS_CYCLES     = 2000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done_out,
  output logic       ack_ok_out,
  output logic       error_out
);

  localparam int MAX_IR = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_C  = (TIMEOUT_CYCLES > MAX_IR) ? TIMEOUT_CYCLES : MAX_IR;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, WAIT_ACK, WAIT_IDLE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          ack;
  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic          fall;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '1;
      ack         <= 1'b0;
      ready_out   <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done_out    <= 1'b0;
      ack_ok_out  <= 1'b0;
      error_out   <= 1'b0;
    end else begin
      done_out  <= 1'b0;
      error_out <= 1'b0;
      case (state)
        IDLE: begin
          ready_out <= 1'b1;
          if (valid_in && ready_out) begin
            // frame bits after start, consumed LSB first: data, odd parity, stop
            shreg      <= {1'b1, ~^data_in, data_in};
            ack_ok_out <= 1'b0;
            ready_out  <= 1'b0;
            ps2_clk_oe <= 1'b1;
            cnt        <= '0;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RTS: begin
          if (cnt == RTS_LAST) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            ps2_clk_oe <= 1'b0;
            state      <= SEND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == TO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done_out    <= 1'b1;
            error_out   <= 1'b1;
            ack_ok_out  <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            case (state)
              SEND: begin
                if (fall) begin
                  ps2_data_oe <= ~shreg[0];
                  shreg       <= {1'b1, shreg[9:1]};
                  bit_cnt     <= bit_cnt + 1'b1;
                  // fall 10 drives the stop bit, which releases the data line
                  if (bit_cnt == 4'd9) state <= WAIT_ACK;
                end
              end
              WAIT_ACK: begin
                if (fall) begin
                  ack   <= ~data_s2;
                  state <= WAIT_IDLE;
                end
              end
              WAIT_IDLE: begin
                if (clk_s2 && data_s2) begin
                  done_out   <= 1'b1;
                  ack_ok_out <= ack;
                  error_out  <= ~ack;
                  state      <= IDLE;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: directed command table against a bit-level PS/2 device model, plus timeout,
// held-valid and mid-frame reset sequences.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int RTS = 10;
  localparam int TO  = 1500;
  localparam int H   = 20;

  logic       clk_pixel = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] data_in   = 8'h00;
  logic       valid_in  = 1'b0;
  logic       ready_out, ps2_clk_oe, ps2_data_oe, done_out, ack_ok_out, error_out;
  logic       dev_clk   = 1'b1;
  logic       dev_data  = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  always #5 clk_pixel = ~clk_pixel;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in     (clk_pixel),
    .rst_in     (rst_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .done_out   (done_out),
    .ack_ok_out (ack_ok_out),
    .error_out  (error_out)
  );

  typedef struct {
    logic [7:0]  dat;
    bit          nack;
    logic [10:0] exp_frame;   // bit i = i-th bit the device samples (start first, stop last)
    bit          exp_ack;
  } vec_t;

  vec_t vecs[5];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic accept(input logic [7:0] d, output bit ok);
    data_in  = d;
    valid_in = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!ready_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic prelude(output int n_clk, output int d_rise);
    n_clk  = 0;
    d_rise = -1;
    while (ps2_clk_oe && n_clk < 5000) begin
      n_clk++;
      if (d_rise < 0 && ps2_data_oe) d_rise = n_clk - 1;
      tick();
    end
  endtask

  task automatic device(input bit nack, input int abort_fall, output logic [10:0] s, output bit aborted);
    s       = '0;
    aborted = 1'b0;
    for (int i = 0; i < 11; i++) begin
      repeat (H) tick();
      s[i] = ps2_data_line;
      if (i == 10) begin
        dev_data = nack;
        repeat (2) tick();
      end
      dev_clk = 1'b0;
      if (i + 1 == abort_fall) begin
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_clk_oe", ps2_clk_oe, 1'b0);
        chk("abort_data_oe", ps2_data_oe, 1'b0);
        chk("abort_ready", ready_out, 1'b1);
        chk("abort_done", done_out, 1'b0);
        aborted  = 1'b1;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        return;
      end
      repeat (H) tick();
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input bit exp_ack, input bit exp_err);
    int n = 0;
    while (!done_out && n < 200) begin
      tick();
      n++;
    end
    chk("done_seen", done_out, 1'b1);
    chk("done_error", error_out, exp_err);
    chk("done_ack_ok", ack_ok_out, exp_ack);
    chk("done_lines_free", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("done_ready_low", ready_out, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok, ab;
    int n_clk, d_rise;
    logic [10:0] s;
    accept(v.dat, ok);
    valid_in = 1'b0;
    chk("accept", ok, 1'b1);
    chk("accept_clk_oe", ps2_clk_oe, 1'b1);
    chk("accept_ack_clr", ack_ok_out, 1'b0);
    prelude(n_clk, d_rise);
    chk("clk_oe_hold", n_clk, INH + RTS);
    chk("data_oe_rise", d_rise, INH);
    device(v.nack, 0, s, ab);
    chk("frame", s, v.exp_frame);
    wait_done(v.exp_ack, !v.exp_ack);
    tick();
    chk("after_done_pulse", {done_out, error_out}, 2'b00);
    chk("after_ready", ready_out, 1'b1);
    chk("after_ack_hold", ack_ok_out, v.exp_ack);
  endtask

  initial begin
    bit ok, ab;
    int n, n_clk, d_rise, seen;
    logic [10:0] s;

    vecs[0] = '{8'hF4, 1'b0, 11'h5E8, 1'b1};
    vecs[1] = '{8'h00, 1'b0, 11'h600, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 11'h7FE, 1'b0};
    vecs[3] = '{8'hA5, 1'b0, 11'h74A, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 11'h402, 1'b0};

    repeat (3) tick();
    chk("rst_ready", ready_out, 1'b1);
    chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("rst_pulses", {done_out, error_out, ack_ok_out}, 3'b000);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_ready", ready_out, 1'b1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // device never clocks: timeout counted from SEND entry
    accept(8'h5A, ok);
    valid_in = 1'b0;
    chk("to_accept", ok, 1'b1);
    prelude(n_clk, d_rise);
    chk("to_start_bit", ps2_data_oe, 1'b1);
    n = 0;
    while (!done_out && n < TO + 50) begin
      tick();
      n++;
    end
    chk("to_cycles", n, TO);
    wait_done(1'b0, 1'b1);
    tick();
    chk("to_ready", ready_out, 1'b1);

    // valid held with 0xFF across a 0xF4 transaction
    accept(8'hF4, ok);
    data_in = 8'hFF;
    chk("hold_accept", ok, 1'b1);
    prelude(n_clk, d_rise);
    device(1'b0, 0, s, ab);
    chk("hold_frame_f4", s, 11'h5E8);
    wait_done(1'b1, 1'b0);
    tick();
    chk("hold_gap_ready", ready_out, 1'b1);
    chk("hold_gap_clk_oe", ps2_clk_oe, 1'b0);
    tick();
    chk("hold_next_accept", {ready_out, ps2_clk_oe}, 2'b01);
    valid_in = 1'b0;
    prelude(n_clk, d_rise);
    chk("hold_clk_oe_hold", n_clk, INH + RTS);
    device(1'b0, 0, s, ab);
    chk("hold_frame_ff", s, 11'h7FE);
    wait_done(1'b1, 1'b0);
    tick();

    // reset during SEND after fall 5
    accept(8'hF4, ok);
    valid_in = 1'b0;
    prelude(n_clk, d_rise);
    device(1'b0, 5, s, ab);
    chk("abort_taken", ab, 1'b1);
    repeat (3) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done_out) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_ready_after", ready_out, 1'b1);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
